// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory with a strobe/resp handshake.
// Alternating priority on ties; a timeout completes a stuck request with an error flag.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_done,
  output logic                  i_err,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_LATCH,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  gnt_d_q, gnt_d_d;    // 1: data port owns the transaction
  logic                  last_d_q, last_d_d;  // 1: last grant went to the data port
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  i_done_q, i_done_d;
  logic                  i_err_q, i_err_d;
  logic                  d_done_q, d_done_d;
  logic                  d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  grant_d_c;

  // Next-state, grant and output logic
  always_comb begin
    state_d     = state_q;
    gnt_d_d     = gnt_d_q;
    last_d_d    = last_d_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    i_err_d     = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d_c   = d_req && (!i_req || !last_d_q);

    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d     = grant_d_c;
          last_d_d    = grant_d_c;
          we_d        = grant_d_c && d_we;
          mem_addr_d  = grant_d_c ? d_addr : i_addr;
          mem_wdata_d = d_wdata;
          cnt_d       = '0;
          mem_read_d  = !(grant_d_c && d_we);
          mem_write_d = grant_d_c && d_we;
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Timeout decision is registered so the compare stays off the next-state path
        tmo_d = (cnt_q == CNT_LAST);
        if (mem_resp) begin
          state_d = ST_LATCH;
        end else if (tmo_q) begin
          i_done_d = !gnt_d_q;
          i_err_d  = !gnt_d_q;
          d_done_d = gnt_d_q;
          d_err_d  = gnt_d_q;
          state_d  = ST_RESP;
        end else begin
          mem_read_d  = mem_read_q;
          mem_write_d = mem_write_q;
        end
      end

      ST_LATCH: begin
        if (!we_q) begin
          if (gnt_d_q) d_rdata_d = mem_rdata;
          else         i_rdata_d = mem_rdata;
        end
        i_done_d = !gnt_d_q;
        d_done_d = gnt_d_q;
        state_d  = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_d_q     <= 1'b0;
      last_d_q    <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_d_q     <= gnt_d_d;
      last_d_q    <= last_d_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      i_err_q     <= i_err_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign i_done    = i_done_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
